// File: rtl/vol_pkg.sv
// ---------------------------------------------------------------------------
// vol_pkg
// Shared definitions for the volume-control slice of the buzzer/audio path.
//   LEVEL_W      width of the volume level (0..MAX_LEVEL)
//   AMP_W        width of one half of the amplitude pair
//   MAX_LEVEL    saturation ceiling of the level counter
//   DEFAULT_STEP amplitude increment per level step
//   level_act_t  decoded action applied to the level register each cycle
//   led_decode() thermometer decode of a level onto the 16-LED bar
// ---------------------------------------------------------------------------
package vol_pkg;

    localparam int LEVEL_W   = 4;
    localparam int AMP_W     = 16;
    localparam int LED_W     = 16;
    localparam int MAX_LEVEL = 15;

    localparam logic [AMP_W-1:0] DEFAULT_STEP = 16'h0600;

    // What the level register does in a given cycle. Exposed so that the
    // decision can be observed alongside the level itself.
    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_UP   = 2'd1,
        ACT_DOWN = 2'd2
    } level_act_t;

    // LED i is lit when i is strictly below the level, so the top LED never
    // lights (level 15 shows 15 LEDs) and level 0 shows an empty bar.
    function automatic logic [LED_W-1:0] led_decode(input logic [LEVEL_W-1:0] level);
        logic [LED_W-1:0] bar;
        bar = '0;
        for (int i = 0; i < LED_W; i++) begin
            bar[i] = (i < int'(level));
        end
        return bar;
    endfunction

endpackage : vol_pkg

// File: rtl/debounce_onepulse.sv
// ---------------------------------------------------------------------------
// debounce_onepulse
// Turns one raw active-low push-button into a single-cycle press pulse.
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   tick   in   sample strobe shared by all buttons (one cycle wide)
//   raw    in   raw button, active-low, asynchronous to clk
//   pulse  out  one-cycle pulse on each released->pressed transition
//
// Path: 2-FF synchroniser -> DB_TAPS-bit sample shift register (advanced on
// tick) -> hysteresis state -> edge register -> pulse.
// ---------------------------------------------------------------------------
module debounce_onepulse #(
    parameter int DB_TAPS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic pulse
);

    // Synchroniser; resets to the released (high) level so a reset never
    // looks like a press on its own.
    logic r_sync1;
    logic r_sync2;

    // Sample history, newest sample in bit 0. All-ones means released.
    logic [DB_TAPS-1:0] r_shift;
    logic [DB_TAPS-1:0] w_shift_next;

    // Debounced state (1 = pressed) and its one-cycle-delayed copy.
    logic r_pressed;
    logic r_pressed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_shift_next = {r_shift[DB_TAPS-2:0], r_sync2};

    // The debounced state follows the history only when it is unanimous;
    // any mixed pattern keeps the previous decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '1;
            r_pressed <= 1'b0;
        end else if (tick) begin
            r_shift <= w_shift_next;
            if (w_shift_next == '0) begin
                r_pressed <= 1'b1;
            end else if (w_shift_next == '1) begin
                r_pressed <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pressed_q <= 1'b0;
        end else begin
            r_pressed_q <= r_pressed;
        end
    end

    // High for exactly the cycle after the debounced state becomes pressed.
    // Built from two registers only, so it is glitch-free.
    assign pulse = r_pressed & ~r_pressed_q;

endmodule : debounce_onepulse

// File: rtl/volume_control.sv
// ---------------------------------------------------------------------------
// volume_control
// Two debounced active-low buttons drive a saturating 4-bit volume level,
// which is decoded into the buzzer amplitude pair and an LED bar.
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   loud_press  in   raw "louder" button, active-low, asynchronous
//   quit_press  in   raw "quieter" button, active-low, asynchronous
//   vol_level   out  current level, 0..15
//   vol_data    out  {+amp, -amp}, 16-bit two's complement halves
//   led         out  thermometer bar, led[i] = (i < vol_level)
// ---------------------------------------------------------------------------
module volume_control
    import vol_pkg::*;
#(
    parameter int               DB_DIV      = 100000,
    parameter int               DB_TAPS     = 4,
    parameter logic [AMP_W-1:0] STEP        = DEFAULT_STEP,
    parameter int               RESET_LEVEL = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 loud_press,
    input  logic                 quit_press,
    output logic [LEVEL_W-1:0]   vol_level,
    output logic [2*AMP_W-1:0]   vol_data,
    output logic [LED_W-1:0]     led
);

    localparam int                 CNT_W   = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DB_DIV - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] LVL_RST = LEVEL_W'(RESET_LEVEL);

    // ------------------------------------------------------------------
    // Sample tick shared by both buttons
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_tick_cnt;
    logic             w_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == CNT_MAX) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick = (r_tick_cnt == CNT_MAX);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic w_up_pulse;
    logic w_down_pulse;

    debounce_onepulse #(
        .DB_TAPS (DB_TAPS)
    ) u_db_loud (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick),
        .raw   (loud_press),
        .pulse (w_up_pulse)
    );

    debounce_onepulse #(
        .DB_TAPS (DB_TAPS)
    ) u_db_quit (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick),
        .raw   (quit_press),
        .pulse (w_down_pulse)
    );

    // ------------------------------------------------------------------
    // Level register
    // ------------------------------------------------------------------
    logic [LEVEL_W-1:0] r_level;
    level_act_t         w_act;

    // Simultaneous up and down cancel; each direction saturates at its end.
    always_comb begin
        w_act = ACT_HOLD;
        if (w_up_pulse && !w_down_pulse && (r_level != LVL_MAX)) begin
            w_act = ACT_UP;
        end else if (w_down_pulse && !w_up_pulse && (r_level != '0)) begin
            w_act = ACT_DOWN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= LVL_RST;
        end else begin
            case (w_act)
                ACT_UP:   r_level <= r_level + 1'b1;
                ACT_DOWN: r_level <= r_level - 1'b1;
                default:  r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode (combinational from the level register)
    // ------------------------------------------------------------------
    logic [AMP_W-1:0] w_amp;
    logic [AMP_W-1:0] w_amp_neg;

    // 15 * STEP must fit in AMP_W bits; with the default step the peak is
    // 0x5A00, leaving the sign bit clear.
    assign w_amp     = AMP_W'(r_level) * STEP;
    assign w_amp_neg = ~w_amp + 1'b1;

    assign vol_level = r_level;
    assign vol_data  = {w_amp, w_amp_neg};
    assign led       = led_decode(r_level);

endmodule : volume_control

// File: tb/tb_volume_control.sv
module tb_volume_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        loud_press;
    logic        quit_press;
    logic [3:0]  vol_level;
    logic [31:0] vol_data;
    logic [15:0] led;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    volume_control #(
        .DB_DIV      (4),
        .DB_TAPS     (4),
        .STEP        (16'h0600),
        .RESET_LEVEL (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .loud_press (loud_press),
        .quit_press (quit_press),
        .vol_level  (vol_level),
        .vol_data   (vol_data),
        .led        (led)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Expected amplitude pair for a level, from the arithmetic definition.
    function automatic logic [31:0] exp_data(input int lvl);
        logic [15:0] a;
        a = 16'(lvl * 32'h0600);
        return {a, 16'h0000 - a};
    endfunction

    function automatic logic [15:0] exp_led(input int lvl);
        logic [31:0] ones;
        ones = (32'h1 << lvl) - 32'h1;
        return ones[15:0];
    endfunction

    // ---------------- driver tasks ----------------
    // Advance n clocks; inputs change and outputs are sampled 1 ns after
    // the rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_level(input string tag, input int lvl);
        check({tag, "_level"}, {28'h0, vol_level}, 32'(lvl));
        check({tag, "_data"},  vol_data,           exp_data(lvl));
        check({tag, "_led"},   {16'h0, led},       {16'h0, exp_led(lvl)});
    endtask

    task automatic press_loud();
        loud_press = 1'b0;
        cyc(40);
        loud_press = 1'b1;
        cyc(40);
    endtask

    task automatic press_quit();
        quit_press = 1'b0;
        cyc(40);
        quit_press = 1'b1;
        cyc(40);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int waited;
        int lvl;

        rst_n      = 1'b0;
        loud_press = 1'b1;
        quit_press = 1'b1;
        cyc(3);

        // Reset values, while reset is still asserted.
        check_level("in_reset", 8);
        check("in_reset_data_const", vol_data, 32'h3000_D000);
        check("in_reset_led_const", {16'h0, led}, 32'h0000_00FF);

        // Idle for 200 cycles: nothing moves.
        rst_n = 1'b1;
        cyc(200);
        check_level("idle", 8);

        // One clean loud press, with latency measured from the falling edge.
        loud_press = 1'b0;
        waited = 0;
        while (vol_level == 4'd8 && waited < 30) begin
            cyc(1);
            waited++;
        end
        check("loud_latency_le_20", {31'h0, (waited <= 20)}, 32'h1);
        cyc(40 - waited);
        loud_press = 1'b1;
        cyc(40);
        check_level("one_press", 9);
        check("one_press_data_const", vol_data, 32'h3600_CA00);
        check("one_press_led_const", {16'h0, led}, 32'h0000_01FF);

        // Short glitch on quit: fewer than 4 consistent samples.
        do_reset();
        quit_press = 1'b0;
        cyc(3);
        quit_press = 1'b1;
        cyc(40);
        check_level("short_glitch", 8);

        // Bouncing quit for 30 cycles; the 5-cycle bounce period drifts
        // against the 4-cycle sample tick so samples never agree 4 times.
        for (int i = 0; i < 6; i++) begin
            quit_press = 1'b0;
            cyc(2);
            quit_press = 1'b1;
            cyc(3);
        end
        cyc(40);
        check_level("bounce", 8);

        // Up to saturation and one beyond.
        for (int i = 1; i <= 8; i++) begin
            press_loud();
            lvl = (8 + i > 15) ? 15 : 8 + i;
            check({"up_", 8'(8'd48 + 8'(i))}, {28'h0, vol_level}, 32'(lvl));
        end
        check_level("top", 15);
        check("top_data_const", vol_data, 32'h5A00_A600);
        check("top_led_const", {16'h0, led}, 32'h0000_7FFF);
        press_loud();
        check_level("top_sat", 15);

        // Down to zero and one beyond.
        for (int i = 1; i <= 15; i++) begin
            press_quit();
            check("down_step", {28'h0, vol_level}, 32'(15 - i));
        end
        check_level("bottom", 0);
        check("bottom_data_const", vol_data, 32'h0000_0000);
        press_quit();
        check_level("bottom_sat", 0);

        // Both buttons at the same cycle cancel.
        do_reset();
        loud_press = 1'b0;
        quit_press = 1'b0;
        cyc(40);
        loud_press = 1'b1;
        quit_press = 1'b1;
        cyc(40);
        check_level("both", 8);

        // Reset in the middle of a held press.
        loud_press = 1'b0;
        cyc(40);
        check_level("hold_pre_rst", 9);
        rst_n = 1'b0;
        cyc(2);
        check_level("hold_in_rst", 8);
        rst_n = 1'b1;
        cyc(40);
        check_level("hold_after_rst", 9);
        cyc(40);
        check_level("hold_still", 9);
        loud_press = 1'b1;
        cyc(40);
        check_level("hold_release", 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_volume_control
